// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - NOP encoding (all-zero word, opcode OP_NOP)
//   - Branch-select (BS) encodings driven by the EX stage
//   - Instruction field bit ranges used by the downstream decoder
package instruction_fetch_stage_pkg;

  localparam int unsigned INSTR_W = 32;

  // Instruction field ranges
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 25;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OP_NOP    = '0;
  localparam logic [INSTR_W-1:0]  NOP_INSTR = '0;

  // Branch-select encodings
  localparam logic [1:0] BS_SEQ  = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_REG  = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_next_pc_mux.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   bs, ps, z       EX-stage branch select, condition invert, zero flag
//   br_addr, raa    immediate/relative target and register target
//   pc, pc_inc      current fetch PC and PC+1
//   hold            stall or imem wait: keep the PC unless redirected
//   take            redirect selected this cycle
//   next_pc         PC value to load on the next edge
module instruction_fetch_stage_next_pc_mux
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic [1:0]          bs,
  input  logic                ps,
  input  logic                z,
  input  logic [PC_WIDTH-1:0] br_addr,
  input  logic [PC_WIDTH-1:0] raa,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] pc_inc,
  input  logic                hold,
  output logic                take,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] target;

  always_comb begin
    take   = 1'b0;
    target = br_addr;
    unique case (bs)
      BS_SEQ:  take = 1'b0;
      BS_COND: take = z ^ ps;
      BS_REG: begin
        take   = 1'b1;
        target = raa;
      end
      BS_JMP:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  // A redirect wins over hold so a branch resolved during a stall is never lost.
  always_comb begin
    next_pc = pc_inc;
    if (take) begin
      next_pc = target;
    end else if (hold) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: holds the fetch PC, drives the instruction-memory address and
// latches the IF/DOF pipeline register (IR, PC+1, valid).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             hazard hold of PC and IF/DOF register
//   imem_addr         instruction-memory address (= pc_q)
//   imem_data/ready   fetched word and its valid strobe
//   bs, ps, z         EX-stage branch controls
//   br_addr, raa      branch targets (immediate / register)
//   pc_q              current fetch PC
//   ir_q, pc_1_q      IF/DOF instruction and its PC+1 (link value)
//   ir_valid          ir_q holds a real instruction (0 = bubble)
//   branch_taken      redirect selected this cycle
// Build option: define IF_BRANCH_FLUSH_EN to squash the instruction fetched
// behind a taken branch; otherwise it executes as a delay slot.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   imem_ready,
  input  logic [1:0]             bs,
  input  logic                   ps,
  input  logic                   z,
  input  logic [PC_WIDTH-1:0]    br_addr,
  input  logic [PC_WIDTH-1:0]    raa,
  output logic [PC_WIDTH-1:0]    pc_q,
  output logic [INSTR_WIDTH-1:0] ir_q,
  output logic [PC_WIDTH-1:0]    pc_1_q,
  output logic                   ir_valid,
  output logic                   branch_taken
);

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(NOP_INSTR);

  logic [PC_WIDTH-1:0]    pc_d;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic [INSTR_WIDTH-1:0] ir_d;
  logic [PC_WIDTH-1:0]    pc_1_d;
  logic                   ir_valid_d;
  logic                   flush;

  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign imem_addr = pc_q;

  instruction_fetch_stage_next_pc_mux #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc_mux (
    .bs      (bs),
    .ps      (ps),
    .z       (z),
    .br_addr (br_addr),
    .raa     (raa),
    .pc      (pc_q),
    .pc_inc  (pc_inc),
    .hold    (stall | ~imem_ready),
    .take    (branch_taken),
    .next_pc (pc_d)
  );

`ifdef IF_BRANCH_FLUSH_EN
  assign flush = branch_taken;
`else
  assign flush = 1'b0;
`endif

  // IF/DOF register: flush > stall > imem wait (bubble) > load.
  always_comb begin
    ir_d       = ir_q;
    pc_1_d     = pc_1_q;
    ir_valid_d = ir_valid;
    if (flush) begin
      ir_d       = NOP_WORD;
      ir_valid_d = 1'b0;
    end else if (stall) begin
      ir_d       = ir_q;
    end else if (!imem_ready) begin
      // Bubble; pc_1_q deliberately keeps its last value.
      ir_d       = NOP_WORD;
      ir_valid_d = 1'b0;
    end else begin
      ir_d       = imem_data;
      pc_1_d     = pc_inc;
      ir_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      ir_q     <= NOP_WORD;
      pc_1_q   <= '0;
      ir_valid <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pc_1_q   <= pc_1_d;
      ir_valid <= ir_valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic [1:0]  bs;
  logic        ps;
  logic        z;
  logic [31:0] br_addr;
  logic [31:0] raa;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] pc_1_q;
  logic        ir_valid;
  logic        branch_taken;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_ready   (imem_ready),
    .bs           (bs),
    .ps           (ps),
    .z            (z),
    .br_addr      (br_addr),
    .raa          (raa),
    .pc_q         (pc_q),
    .ir_q         (ir_q),
    .pc_1_q       (pc_1_q),
    .ir_valid     (ir_valid),
    .branch_taken (branch_taken)
  );

  // Instruction memory contents: a word that encodes its own address.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return {a[15:0], 16'hBEEF};
  endfunction

  assign imem_data = instr_at(imem_addr);

  // Reference rules
  function automatic logic m_take(input logic [1:0] b, input logic p, input logic zz);
    if (b == 2'd0) return 1'b0;
    if (b == 2'd1) return zz != p;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_target(input logic [1:0] b, input logic [31:0] ba,
                                           input logic [31:0] ra);
    return (b == 2'd2) ? ra : ba;
  endfunction

`ifdef IF_BRANCH_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic [31:0] m_pc, m_ir, m_pc1;
  logic        m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= 32'h0;
      m_ir    <= 32'h0;
      m_pc1   <= 32'h0;
      m_valid <= 1'b0;
    end else begin
      if (m_take(bs, ps, z)) m_pc <= m_target(bs, br_addr, raa);
      else if (stall || !imem_ready) m_pc <= m_pc;
      else m_pc <= m_pc + 32'd1;

      if (FLUSH && m_take(bs, ps, z)) begin
        m_ir    <= 32'h0;
        m_valid <= 1'b0;
      end else if (stall) begin
        m_ir <= m_ir;
      end else if (!imem_ready) begin
        m_ir    <= 32'h0;
        m_valid <= 1'b0;
      end else begin
        m_ir    <= instr_at(m_pc);
        m_pc1   <= m_pc + 32'd1;
        m_valid <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("imem_addr", imem_addr, m_pc);
    check("pc_q", pc_q, m_pc);
    check("ir_q", ir_q, m_ir);
    check("pc_1_q", pc_1_q, m_pc1);
    check("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    check("branch_taken", {31'b0, branch_taken}, {31'b0, m_take(bs, ps, z)});
  end

  task automatic drive(input logic [1:0] b, input logic p, input logic zz,
                       input logic [31:0] ba, input logic [31:0] ra,
                       input logic st, input logic rdy);
    bs = b; ps = p; z = zz; br_addr = ba; raa = ra; stall = st; imem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #12;
    check("rst_pc", pc_q, 32'h0);
    check("rst_ir", ir_q, 32'h0);
    check("rst_pc1", pc_1_q, 32'h0);
    check("rst_valid", {31'b0, ir_valid}, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch
    tick();
    check("seq_pc", pc_q, 32'h1);
    check("seq_ir", ir_q, 32'h0000_BEEF);
    check("seq_pc1", pc_1_q, 32'h1);
    tick(); tick(); tick();
    check("seq_pc4", pc_q, 32'h4);
    tick();

    // BZ taken at pc=5
    drive(2'd1, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b1);
    #1;
    check("bz_taken", {31'b0, branch_taken}, 32'h1);
    tick();
    check("bz_pc", pc_q, 32'h40);
    check("bz_ir", ir_q, FLUSH ? 32'h0 : 32'h0005_BEEF);
    check("bz_valid", {31'b0, ir_valid}, FLUSH ? 32'h0 : 32'h1);
    drive(2'd1, 1'b0, 1'b0, 32'h90, 32'h0, 1'b0, 1'b1);
    tick();
    check("bz_not_taken_pc", pc_q, 32'h41);
    drive(2'd1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1);
    tick();
    check("bnz_pc", pc_q, 32'h80);

    // JMR, JMP
    drive(2'd2, 1'b0, 1'b0, 32'h40, 32'h123, 1'b0, 1'b1);
    tick();
    check("jmr_pc", pc_q, 32'h123);
    drive(2'd3, 1'b0, 1'b0, 32'h200, 32'h123, 1'b0, 1'b1);
    tick();
    check("jmp_pc", pc_q, 32'h200);
    drive(2'd3, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1);
    tick();

    // Stall at pc=8
    drive(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    tick(); tick(); tick();
    check("stall_pc", pc_q, 32'h8);
    check("stall_ir", ir_q, FLUSH ? 32'h0 : 32'h0200_BEEF);
    drive(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check("stall_release_pc", pc_q, 32'h9);
    drive(2'd3, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1);
    tick();
    check("stall_jmp_pc", pc_q, 32'h10);

    // imem wait states
    drive(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    check("wait_pc", pc_q, 32'h10);
    check("wait_ir", ir_q, 32'h0);
    check("wait_valid", {31'b0, ir_valid}, 32'h0);
    drive(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check("resume_pc", pc_q, 32'h11);
    check("resume_ir", ir_q, 32'h0010_BEEF);

    // PC wrap
    drive(2'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    tick();
    drive(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check("wrap_pc", pc_q, 32'h0);
    check("wrap_pc1", pc_1_q, 32'h0);
    tick();

    // Asynchronous reset mid-branch
    drive(2'd3, 1'b0, 1'b0, 32'h77, 32'h0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc_q, 32'h0);
    check("async_rst_valid", {31'b0, ir_valid}, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick(); tick(); tick();
    check("post_rst_pc", pc_q, 32'h3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
